// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: paces ADC conversions on a fixed interval, averages 2^N
// samples per channel and hands the averaged pair to the PID datapath over a
// valid/ready handshake. Sticky flags report dropped ticks and missing strobes.
//
// state | meaning
// IDLE  | schedule stopped, waiting for enable
// WAIT  | waiting for the interval tick to launch a conversion
// CONV  | conversion in flight, waiting for adc_done or the timeout
// OUT   | averaged pair presented, waiting for out_ready

module adc_sample_ctrl #(
  parameter int DATA_W  = 12,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [15:0]       period,
  input  logic [1:0]        avg_log2,
  input  logic              clr_flags,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data1,
  input  logic [DATA_W-1:0] adc_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic              overrun,
  output logic              timeout,
  output logic              busy
);

  // Three guard bits hold eight full-scale samples without wrapping.
  localparam int ACC_W = DATA_W + 3;
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CONV, OUT} state_t;

  state_t           state;
  logic [15:0]      timer;
  logic [15:0]      p_lat;
  logic [15:0]      p_eff;
  logic [1:0]       avg_lat;
  logic [ACC_W-1:0] acc1, acc2;
  logic [ACC_W-1:0] sum1, sum2;
  logic [3:0]       samp_cnt, samp_next, samp_target;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tick;

  // Effective period, next accumulator values and the interval tick.
  always_comb begin
    p_eff       = (period < 16'd2) ? 16'd2 : period;
    sum1        = acc1 + ACC_W'(adc_data1);
    sum2        = acc2 + ACC_W'(adc_data2);
    samp_next   = samp_cnt + 4'd1;
    samp_target = 4'd1 << avg_lat;
    // >= rather than == so a re-latched shorter period cannot strand the timer.
    tick        = enable && (state != IDLE) && (timer >= p_lat - 16'd1);
  end

  // Interval timer: free-runs 0..P-1 while scheduling, held at 0 otherwise.
  always_ff @(posedge clk) begin
    if (!rstn || !enable || state == IDLE) timer <= '0;
    else if (tick)                         timer <= '0;
    else                                   timer <= timer + 16'd1;
  end

  // Sequencer FSM with registered outputs, accumulators and sticky flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      p_lat     <= 16'd2;
      avg_lat   <= '0;
      acc1      <= '0;
      acc2      <= '0;
      samp_cnt  <= '0;
      tmo_cnt   <= '0;
      adc_start <= 1'b0;
      out_valid <= 1'b0;
      out_data1 <= '0;
      out_data2 <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      if (clr_flags) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
      end
      // A tick that cannot launch a conversion is lost; set wins over clear.
      if (tick && (state == CONV || state == OUT)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (enable) begin
            p_lat    <= p_eff;
            avg_lat  <= avg_log2;
            acc1     <= '0;
            acc2     <= '0;
            samp_cnt <= '0;
            state    <= WAIT;
            busy     <= 1'b1;
          end
        end
        WAIT: begin
          if (!enable) begin
            acc1     <= '0;
            acc2     <= '0;
            samp_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end else if (tick) begin
            adc_start <= 1'b1;
            tmo_cnt   <= TMO_LOAD;
            state     <= CONV;
          end
        end
        CONV: begin
          if (!enable) begin
            acc1     <= '0;
            acc2     <= '0;
            samp_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end else if (adc_done) begin
            acc1     <= sum1;
            acc2     <= sum2;
            samp_cnt <= samp_next;
            if (samp_next == samp_target) begin
              out_data1 <= DATA_W'(sum1 >> avg_lat);
              out_data2 <= DATA_W'(sum2 >> avg_lat);
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              state <= WAIT;
            end
          end else if (tmo_cnt == '0) begin
            timeout <= 1'b1;
            state   <= WAIT;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc1      <= '0;
            acc2      <= '0;
            samp_cnt  <= '0;
            p_lat     <= p_eff;
            avg_lat   <= avg_log2;
            state     <= enable ? WAIT : IDLE;
            busy      <= enable;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Testbench for adc_sample_ctrl: an ADC responder feeds queued samples, a
// bench-side averaging model pushes expected pairs, and a monitor pops and
// compares them whenever the DUT hands off an output.

module tb_adc_sample_ctrl;

  localparam int DW       = 12;
  localparam int TMO      = 255;
  localparam int DONE_DLY = 3;

  logic          clk       = 1'b0;
  logic          rstn      = 1'b0;
  logic          enable    = 1'b0;
  logic [15:0]   period    = 16'd10;
  logic [1:0]    avg_log2  = 2'd0;
  logic          clr_flags = 1'b0;
  logic          adc_done  = 1'b0;
  logic [DW-1:0] adc_data1 = '0;
  logic [DW-1:0] adc_data2 = '0;
  logic          out_ready = 1'b1;
  logic          adc_start, out_valid, overrun, timeout, busy;
  logic [DW-1:0] out_data1, out_data2;

  adc_sample_ctrl #(.DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .period    (period),
    .avg_log2  (avg_log2),
    .clr_flags (clr_flags),
    .adc_start (adc_start),
    .adc_done  (adc_done),
    .adc_data1 (adc_data1),
    .adc_data2 (adc_data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .overrun   (overrun),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int ov_cycles = 0;
  int start_in_out = 0;
  logic adc_en = 1'b1;
  logic [2*DW-1:0] sample_q[$];
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] adc_s, exp_s;
  int m_avg = 0;
  int m_n = 0;
  int unsigned m_acc1 = 0;
  int unsigned m_acc2 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Queue one ADC sample; once a group is complete, queue its expected average.
  task automatic push_sample(input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    sample_q.push_back({d1, d2});
    m_acc1 += d1;
    m_acc2 += d2;
    m_n++;
    if (m_n == (1 << m_avg)) begin
      exp_q.push_back({DW'(m_acc1 >> m_avg), DW'(m_acc2 >> m_avg)});
      m_acc1 = 0;
      m_acc2 = 0;
      m_n    = 0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!adc_start && n < budget);
    if (!adc_start) chk("adc_start_seen", 32'd0, 32'd1);
  endtask

  task automatic wait_outs(input int target, input int budget);
    int n = 0;
    while (n_out < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("outs_within_budget", 32'(n_out >= target), 32'd1);
  endtask

  // ADC responder: answers each adc_start with one done strobe DONE_DLY cycles later.
  always @(negedge clk) begin
    if (adc_en && adc_start) begin
      if (sample_q.size() > 0) adc_s = sample_q.pop_front();
      else                     adc_s = {12'h123, 12'hABC};
      repeat (DONE_DLY) @(negedge clk);
      adc_data1 = adc_s[2*DW-1:DW];
      adc_data2 = adc_s[DW-1:0];
      adc_done  = 1'b1;
      @(negedge clk);
      adc_done  = 1'b0;
    end
  end

  // Scoreboard monitor: compares every accepted output against the queue.
  always @(negedge clk) begin
    #1;
    if (out_valid) ov_cycles++;
    if (adc_start && out_valid) start_in_out++;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_s = exp_q.pop_front();
        chk("sb_data1", 32'(out_data1), 32'(exp_s[2*DW-1:DW]));
        chk("sb_data2", 32'(out_data2), 32'(exp_s[DW-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    logic [DW-1:0] h1, h2;
    logic held_ok;

    // Reset state
    cycles(3);
    chk("rst_adc_start", 32'(adc_start), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data1", 32'(out_data1), 32'd0);
    chk("rst_out_data2", 32'(out_data2), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    cycles(1);

    // Single-sample outputs at period 10
    m_avg = 0; avg_log2 = 2'd0; period = 16'd10;
    repeat (3) push_sample(12'h123, 12'hABC);
    base = ov_cycles;
    enable = 1'b1;
    wait_start(50, n); chk("t1_first_start", n, 11);
    wait_start(50, n); chk("t1_interval_a", n, 10);
    wait_start(50, n); chk("t1_interval_b", n, 10);
    cycles(6);
    enable = 1'b0;
    cycles(2);
    chk("t1_outs", n_out, 3);
    chk("t1_valid_cycles", ov_cycles - base, 3);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Average of four
    m_avg = 2; avg_log2 = 2'd2;
    push_sample(12'd100, 12'd7);
    push_sample(12'd101, 12'd8);
    push_sample(12'd102, 12'd9);
    push_sample(12'd105, 12'd10);
    base = n_out;
    enable = 1'b1;
    wait_outs(base + 1, 200);
    enable = 1'b0;
    cycles(2);

    // Average of eight at full scale, no wrap
    m_avg = 3; avg_log2 = 2'd3;
    for (int i = 0; i < 8; i++) push_sample(12'hFFF, 12'(12'h800 + i));
    base = n_out;
    enable = 1'b1;
    wait_outs(base + 1, 200);
    enable = 1'b0;
    cycles(2);

    // Backpressure at period 4: hold output, flag overrun, then resume
    m_avg = 0; avg_log2 = 2'd0; period = 16'd4; out_ready = 1'b0;
    push_sample(12'h111, 12'h222);
    push_sample(12'h333, 12'h444);
    push_sample(12'h555, 12'h666);
    base = n_out;
    enable = 1'b1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid_seen", 32'(out_valid), 32'd1);
    h1 = out_data1; h2 = out_data2; held_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_data1 !== h1 || out_data2 !== h2) held_ok = 1'b0;
    end
    chk("t4_hold_stable", 32'(held_ok), 32'd1);
    chk("t4_hold_data1", 32'(h1), 32'h111);
    chk("t4_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    wait_outs(base + 3, 100);
    enable = 1'b0;
    cycles(2);
    chk("t4_start_in_out", start_in_out, 0);
    clr_flags = 1'b1;
    cycles(1);
    clr_flags = 1'b0;
    chk("t4_overrun_clr", 32'(overrun), 32'd0);

    // Timeout with no done strobe
    adc_en = 1'b0; period = 16'd10;
    enable = 1'b1;
    wait_start(50, n);
    n = 0;
    while (!timeout && n < TMO + 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_timeout_lat", n, TMO);
    chk("t5_busy", 32'(busy), 32'd1);
    wait_start(20, n); chk("t5_restart_lat", n, 5);
    clr_flags = 1'b1;
    cycles(1);
    clr_flags = 1'b0;
    chk("t5_timeout_clr", 32'(timeout), 32'd0);
    enable = 1'b0;
    cycles(2);
    adc_en = 1'b1;

    // Reset mid-conversion; the late done strobe must be ignored
    enable = 1'b1;
    wait_start(50, n);
    cycles(1);
    rstn = 1'b0; enable = 1'b0;
    cycles(1);
    chk("t6_adc_start", 32'(adc_start), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_data1", 32'(out_data1), 32'd0);
    chk("t6_out_data2", 32'(out_data2), 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd0);
    chk("t6_timeout", 32'(timeout), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    base = n_out;
    cycles(4);
    chk("t6_no_out", n_out, base);
    chk("t6_busy_after", 32'(busy), 32'd0);
    chk("t6_data_after", 32'(out_data1), 32'd0);

    // Enable dropped during conversion
    enable = 1'b1;
    wait_start(50, n);
    enable = 1'b0;
    cycles(1);
    chk("t7_busy_idle", 32'(busy), 32'd0);
    base = n_out;
    cycles(5);
    chk("t7_no_out", n_out, base);
    chk("t7_out_valid", 32'(out_valid), 32'd0);

    // Period 0 behaves as period 2
    m_avg = 0; avg_log2 = 2'd0; period = 16'd0;
    push_sample(12'h5A5, 12'h0F0);
    push_sample(12'h3C3, 12'hF0F);
    enable = 1'b1;
    wait_start(20, n); chk("p0_first_start", n, 3);
    wait_start(20, n); chk("p0_interval", n, 6);
    cycles(5);
    enable = 1'b0;
    cycles(3);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
